// File: rtl/frame_ram_writer_pkg.sv
// Shared types and constants for the frame RAM capture path.
// Depth and sample width match the frame RAM read by the FFT side.
package frame_ram_writer_pkg;

  localparam int FRAME_DEPTH = 1024;
  localparam int SAMPLE_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DONE
  } wr_state_t;

  // A zero or oversize request means a full frame.
  function automatic int unsigned eff_len(
    input int unsigned len,
    input int unsigned depth
  );
    return (len == 0 || len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/frame_ram_writer_if.sv
// Valid/ready sample stream feeding the frame RAM writer.
// The master produces samples, the slave (writer) accepts them.
interface frame_ram_writer_if #(
  parameter int DATA_W = 32
);

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/frame_ram_writer_sample_decimator.sv
// Keeps one of every DECIM accepted samples.
// The keep strobe fires on the DECIM-th accept of each group.
module sample_decimator #(
  parameter int DECIM = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_accept,
  output logic o_keep
);

  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0] LAST = CW'(DECIM - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_cnt;

  assign o_keep = i_accept && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_accept) begin
      r_cnt <= o_keep ? '0 : r_cnt + ONE;
    end
  end

endmodule

// File: rtl/frame_ram_writer.sv
// Captures a stream of filter samples into the frame RAM,
// writing len words from address 0 and pulsing done.
module frame_ram_writer
  import frame_ram_writer_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int ADDR_W = $clog2(FRAME_DEPTH),
  parameter int DECIM  = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  frame_ram_writer_if.slave s,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written,
  output logic [CNT_W-1:0]  frame_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);
  localparam logic [CNT_W-1:0] FC_ONE = CNT_W'(1);

  wr_state_t         r_state;
  logic [ADDR_W:0]   r_len_eff;
  logic [ADDR_W:0]   r_wr_ptr;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_din;
  logic              r_done;
  logic [CNT_W-1:0]  r_frame_cnt;

  logic            w_accept;
  logic            w_keep;
  logic            w_start;
  logic [ADDR_W:0] w_ptr_nxt;

  assign s.s_ready = (r_state == ST_CAPTURE);
  assign w_accept  = s.s_valid && s.s_ready;
  assign w_start   = start && (r_state == ST_IDLE);
  assign w_ptr_nxt = r_wr_ptr + ONE;

  sample_decimator #(
    .DECIM(DECIM)
  ) u_dec (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_start),
    .i_accept(w_accept),
    .o_keep  (w_keep)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_len_eff   <= '0;
      r_wr_ptr    <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_ram_we <= 1'b0;
      r_done   <= 1'b0;
      unique case (1'b1)
        (r_state == ST_IDLE): begin
          if (start) begin
            r_len_eff <= (ADDR_W + 1)'(
              eff_len(32'(len), DEPTH));
            r_wr_ptr  <= '0;
            r_state   <= ST_CAPTURE;
          end
        end
        (r_state == ST_CAPTURE): begin
          if (w_keep) begin
            r_ram_we   <= 1'b1;
            r_ram_addr <= r_wr_ptr[ADDR_W-1:0];
            r_ram_din  <= s.s_data;
            r_wr_ptr   <= w_ptr_nxt;
            // Leave before the next edge so no extra sample is accepted.
            if (w_ptr_nxt == r_len_eff) begin
              r_state <= ST_DONE;
            end
          end
        end
        (r_state == ST_DONE): begin
          r_done      <= 1'b1;
          r_frame_cnt <= r_frame_cnt + FC_ONE;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ram_we        = r_ram_we;
  assign ram_addr      = r_ram_addr;
  assign ram_din       = r_ram_din;
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;
  assign words_written = r_wr_ptr;
  assign frame_count   = r_frame_cnt;

endmodule

// File: tb/tb_frame_ram_writer.sv
// Randomised bench for frame_ram_writer, DECIM=1 and DECIM=2,
// checked against a sample-level model of the capture.
module tb_frame_ram_writer;
  import frame_ram_writer_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start [2];
  logic [AW:0]   len   [2];
  logic          v     [2];
  logic [DW-1:0] dat   [2];
  logic          rdy   [2];
  logic          we    [2];
  logic          busy  [2];
  logic          done  [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] din   [2];
  logic [AW:0]   ww    [2];
  logic [CW-1:0] fc    [2];

  frame_ram_writer_if #(.DATA_W(DW)) sif0 ();
  frame_ram_writer_if #(.DATA_W(DW)) sif1 ();

  assign sif0.s_valid = v[0];
  assign sif0.s_data  = dat[0];
  assign rdy[0]       = sif0.s_ready;
  assign sif1.s_valid = v[1];
  assign sif1.s_data  = dat[1];
  assign rdy[1]       = sif1.s_ready;

  frame_ram_writer #(
    .DATA_W(DW), .ADDR_W(AW), .DECIM(1), .CNT_W(CW)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .len(len[0]),
    .s(sif0), .ram_we(we[0]), .ram_addr(addr[0]),
    .ram_din(din[0]), .busy(busy[0]), .done(done[0]),
    .words_written(ww[0]), .frame_count(fc[0])
  );

  frame_ram_writer #(
    .DATA_W(DW), .ADDR_W(AW), .DECIM(2), .CNT_W(CW)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .len(len[1]),
    .s(sif1), .ram_we(we[1]), .ram_addr(addr[1]),
    .ram_din(din[1]), .busy(busy[1]), .done(done[1]),
    .words_written(ww[1]), .frame_count(fc[1])
  );

  int errors = 0;
  int checks = 0;
  int fc_m [2];
  logic [AW-1:0] last_a [2];
  logic [DW-1:0] last_d [2];

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rdy[d], we[d], busy[d], done[d]} !== 4'b0) begin
        errors++;
        $display("FAIL reset_ctl d%0d: got %b want 0000", d,
                 {rdy[d], we[d], busy[d], done[d]});
      end
      checks++;
      if (addr[d] !== '0 || din[d] !== '0 ||
          ww[d] !== '0 || fc[d] !== '0) begin
        errors++;
        $display("FAIL reset_data d%0d: addr %0h din %0h ww %0d fc %0d want 0",
                 d, addr[d], din[d], ww[d], fc[d]);
      end
    end
  endtask

  // One frame: vmode 0 = valid always, 1 = toggling, 2 = random.
  task automatic capture(input int d, input int len_in,
                         input int vmode, input logic [31:0] base,
                         input bit inj, input int chain_len,
                         input bit pre);
    int leff, dm, kept, acc, wr, cyc, budget;
    int done_n, last_we_cyc, done_cyc, post;
    logic [DW-1:0] exp_q [$];
    bit mr;
    leff = (len_in == 0 || len_in > DEPTH) ? DEPTH : len_in;
    dm = (d == 1) ? 2 : 1;
    if (!pre) begin
      @(negedge clk);
      start[d] = 1'b1;
      len[d] = (AW + 1)'(len_in);
    end
    @(negedge clk);
    start[d] = 1'b0;
    v[d] = 1'b0;
    kept = 0; acc = 0; wr = 0; cyc = 0; post = 0; done_n = 0;
    last_we_cyc = -1; done_cyc = -2;
    budget = leff * dm * 5 + 50;
    while (1) begin
      start[d] = 1'b0;
      if (we[d]) begin
        checks++;
        if (wr >= exp_q.size() || addr[d] !== AW'(wr) ||
            din[d] !== exp_q[wr]) begin
          errors++;
          $display("FAIL write d%0d #%0d: addr %0d din %0h want addr %0d din %0h",
                   d, wr, addr[d], din[d], wr,
                   (wr < exp_q.size()) ? exp_q[wr] : 32'hx);
        end
        last_a[d] = AW'(wr);
        last_d[d] = (wr < exp_q.size()) ? exp_q[wr] : din[d];
        wr++;
        last_we_cyc = cyc;
      end else begin
        checks++;
        if (addr[d] !== last_a[d] || din[d] !== last_d[d]) begin
          errors++;
          $display("FAIL hold d%0d: addr %0h din %0h want %0h %0h",
                   d, addr[d], din[d], last_a[d], last_d[d]);
        end
      end
      checks++;
      if (ww[d] !== (AW + 1)'(wr)) begin
        errors++;
        $display("FAIL words_written d%0d: got %0d want %0d",
                 d, ww[d], wr);
      end
      if (done[d]) begin
        done_n++;
        done_cyc = cyc;
        checks++;
        if (fc[d] !== CW'(fc_m[d] + 1)) begin
          errors++;
          $display("FAIL frame_count d%0d: got %0d want %0d",
                   d, fc[d], fc_m[d] + 1);
        end
      end
      mr = (kept < leff);
      checks++;
      if (rdy[d] !== mr) begin
        errors++;
        $display("FAIL s_ready d%0d cyc %0d: got %b want %b",
                 d, cyc, rdy[d], mr);
      end
      if (done_n > 0) post++;
      if (inj && cyc == 5) begin
        start[d] = 1'b1;
        len[d] = (AW + 1)'(3);
      end
      if (inj && wr == leff && done_n == 0) begin
        start[d] = 1'b1;
        len[d] = (AW + 1)'(5);
      end
      if (done[d] && chain_len > 0) begin
        start[d] = 1'b1;
        len[d] = (AW + 1)'(chain_len);
        break;
      end
      if (post >= 4 || cyc > budget) break;
      if (vmode == 0) v[d] = 1'b1;
      else if (vmode == 1) v[d] = (cyc % 2 == 0);
      else v[d] = ($urandom_range(0, 3) != 0);
      dat[d] = v[d] ? DW'(base + 32'(acc)) : DW'($urandom);
      if (v[d] && mr) begin
        acc++;
        if (acc % dm == 0) begin
          exp_q.push_back(dat[d]);
          kept++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    v[d] = 1'b0;
    checks++;
    if (cyc > budget) begin
      errors++;
      $display("FAIL timeout d%0d len %0d: no done in %0d cycles",
               d, len_in, budget);
    end
    checks++;
    if (wr != leff) begin
      errors++;
      $display("FAIL write_count d%0d len %0d: got %0d want %0d",
               d, len_in, wr, leff);
    end
    checks++;
    if (done_n != 1) begin
      errors++;
      $display("FAIL done_count d%0d: got %0d want 1", d, done_n);
    end
    checks++;
    if (done_cyc != last_we_cyc + 1) begin
      errors++;
      $display("FAIL done_timing d%0d: done cyc %0d last write cyc %0d",
               d, done_cyc, last_we_cyc);
    end
    fc_m[d]++;
  endtask

  task automatic test_basic();
    capture(0, 64, 0, 32'h1000, 1'b0, 0, 1'b0);
  endtask

  task automatic test_toggle();
    capture(0, 64, 1, $urandom, 1'b0, 0, 1'b0);
  endtask

  task automatic test_decim();
    capture(1, 64, 0, 32'h0, 1'b0, 0, 1'b0);
    capture(1, 37, 2, $urandom, 1'b0, 0, 1'b0);
  endtask

  task automatic test_len_bounds();
    capture(0, 0, 2, $urandom, 1'b0, 0, 1'b0);
    capture(0, 1, 0, $urandom, 1'b0, 0, 1'b0);
    capture(0, 1500, 0, $urandom, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reset_abort();
    int n, cyc;
    @(negedge clk);
    start[0] = 1'b1;
    len[0] = (AW + 1)'(20);
    @(negedge clk);
    start[0] = 1'b0;
    n = 0; cyc = 0;
    while (n < 10 && cyc < 100) begin
      v[0] = 1'b1;
      dat[0] = DW'($urandom);
      @(negedge clk);
      if (we[0]) n++;
      cyc++;
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL abort_setup: got %0d writes want 10", n);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({we[0], rdy[0], busy[0], done[0]} !== 4'b0) begin
      errors++;
      $display("FAIL abort_ctl: got %b want 0000",
               {we[0], rdy[0], busy[0], done[0]});
    end
    checks++;
    if (ww[0] !== '0 || fc[0] !== '0 || addr[0] !== '0) begin
      errors++;
      $display("FAIL abort_data: ww %0d fc %0d addr %0d want 0",
               ww[0], fc[0], addr[0]);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (we[0] !== 1'b0 || done[0] !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet cyc %0d: we %b done %b want 0 0",
                 i, we[0], done[0]);
      end
    end
    v[0] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      fc_m[d] = 0;
      last_a[d] = '0;
      last_d[d] = '0;
    end
    capture(0, 8, 0, $urandom, 1'b0, 0, 1'b0);
  endtask

  task automatic test_start_ignored();
    capture(0, 16, 2, $urandom, 1'b1, 12, 1'b0);
    capture(0, 12, 0, $urandom, 1'b0, 9, 1'b1);
    capture(0, 9, 1, $urandom, 1'b0, 0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      len[d] = '0;
      v[d] = 1'b0;
      dat[d] = '0;
      fc_m[d] = 0;
      last_a[d] = '0;
      last_d[d] = '0;
    end
    test_reset();
    test_basic();
    test_toggle();
    test_decim();
    test_len_bounds();
    test_reset_abort();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
